// File: rtl/issue_ctrl.sv
// Issue controller between decode and execute.
// Tracks in-flight register writers with one busy bit per S and P register
// and holds back any instruction with a RAW or WAW hazard. Branches are
// serialised until they resolve, and HALT drains the pipe before stopping.
// A single output register feeds the execute stage.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   RUN     | normal issue
//   BR_WAIT | branch issued; wait for br_resolved before issuing again
//   DRAIN   | HALT issued; wait for writers and the issue register to empty
//   HALTED  | pipe drained after HALT; only reset leaves this state
module issue_ctrl #(
    parameter int WIDTH        = 32,
    parameter int REG_SEL      = 5,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [WIDTH-1:0]   dec_inst,
    input  logic               dec_is_branch,
    input  logic               dec_halted,
    input  logic               dec_a_from_rb,
    input  logic               dec_a_sel,
    input  logic [REG_SEL-1:0] dec_a_addr,
    input  logic               dec_b_from_rb,
    input  logic [REG_SEL-1:0] dec_b_addr,
    input  logic               dec_z_sel,
    input  logic [REG_SEL-1:0] dec_z_addr,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [WIDTH-1:0]   iss_inst,
    input  logic               wb_valid,
    input  logic               wb_sel,
    input  logic [REG_SEL-1:0] wb_addr,
    input  logic               br_resolved,
    input  logic               br_taken,
    output logic               flush,
    output logic               halted,
    output logic               sb_err
);

    localparam int NREG = 1 << REG_SEL;
    localparam int CW   = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {RUN, BR_WAIT, DRAIN, HALTED} state_t;

    state_t            state_q, state_d;
    logic [NREG-1:0]   busy_s_q, busy_s_d;
    logic [NREG-1:0]   busy_p_q, busy_p_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic              iss_valid_q, iss_valid_d;
    logic [WIDTH-1:0]  iss_inst_q, iss_inst_d;
    logic              halted_q, halted_d;
    logic              sb_err_q, sb_err_d;

    logic writes_z, a_busy, b_busy, z_busy, hazard;
    logic accept, acc_wr, wb_ok, br_ok;

    // Hazard detection, handshake and flush; wb/br are ignored while in reset
    always_comb begin
        writes_z  = !dec_is_branch && !dec_halted;
        a_busy    = dec_a_sel ? busy_p_q[dec_a_addr] : busy_s_q[dec_a_addr];
        b_busy    = busy_s_q[dec_b_addr];
        z_busy    = dec_z_sel ? busy_p_q[dec_z_addr] : busy_s_q[dec_z_addr];
        hazard    = (dec_a_from_rb && a_busy) || (dec_b_from_rb && b_busy) ||
                    (writes_z && z_busy);
        dec_ready = !rst && (state_q == RUN) && !hazard &&
                    (!iss_valid_q || iss_ready) &&
                    (!writes_z || (inflight_q < CW'(MAX_INFLIGHT)));
        accept    = dec_valid && dec_ready;
        acc_wr    = accept && writes_z;
        wb_ok     = wb_valid && !rst;
        br_ok     = br_resolved && (state_q == BR_WAIT) && !rst;
        flush     = br_ok && br_taken;
    end

    // Next-state: scoreboard (set beats clear), inflight count, issue register, FSM
    always_comb begin
        busy_s_d = busy_s_q;
        busy_p_d = busy_p_q;
        if (wb_ok) begin
            if (wb_sel) busy_p_d[wb_addr] = 1'b0;
            else        busy_s_d[wb_addr] = 1'b0;
        end
        if (acc_wr) begin
            if (dec_z_sel) busy_p_d[dec_z_addr] = 1'b1;
            else           busy_s_d[dec_z_addr] = 1'b1;
        end

        inflight_d = inflight_q;
        if (acc_wr && !wb_ok)
            inflight_d = inflight_q + CW'(1);
        else if (!acc_wr && wb_ok && (inflight_q != '0))
            inflight_d = inflight_q - CW'(1);

        sb_err_d = sb_err_q || (wb_ok && (inflight_q == '0));

        iss_valid_d = iss_valid_q;
        iss_inst_d  = iss_inst_q;
        if (accept) begin
            iss_valid_d = 1'b1;
            iss_inst_d  = dec_inst;
        end else if (br_ok || iss_ready) begin
            iss_valid_d = 1'b0;
        end

        state_d = state_q;
        case (state_q)
            RUN: begin
                if (accept && dec_is_branch)   state_d = BR_WAIT;
                else if (accept && dec_halted) state_d = DRAIN;
            end
            BR_WAIT: if (br_ok) state_d = RUN;
            DRAIN:   if ((inflight_d == '0) && !iss_valid_d) state_d = HALTED;
            default: state_d = HALTED;
        endcase

        halted_d = halted_q || (state_d == HALTED);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            busy_s_q    <= '0;
            busy_p_q    <= '0;
            inflight_q  <= '0;
            iss_valid_q <= 1'b0;
            iss_inst_q  <= '0;
            halted_q    <= 1'b0;
            sb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_s_q    <= busy_s_d;
            busy_p_q    <= busy_p_d;
            inflight_q  <= inflight_d;
            iss_valid_q <= iss_valid_d;
            iss_inst_q  <= iss_inst_d;
            halted_q    <= halted_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_inst  = iss_inst_q;
    assign halted    = halted_q;
    assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Randomised bench for issue_ctrl. A behavioural model predicts the handshake,
// flush, halt and error outputs each cycle; accepted instruction words are
// queued and a separate monitor checks them as execute consumes them.
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_inst;
    logic        dec_is_branch, dec_halted;
    logic        dec_a_from_rb, dec_a_sel;
    logic [4:0]  dec_a_addr;
    logic        dec_b_from_rb;
    logic [4:0]  dec_b_addr;
    logic        dec_z_sel;
    logic [4:0]  dec_z_addr;
    logic        iss_valid, iss_ready;
    logic [31:0] iss_inst;
    logic        wb_valid, wb_sel;
    logic [4:0]  wb_addr;
    logic        br_resolved, br_taken;
    logic        flush, halted, sb_err;

    issue_ctrl dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
        .dec_is_branch(dec_is_branch), .dec_halted(dec_halted),
        .dec_a_from_rb(dec_a_from_rb), .dec_a_sel(dec_a_sel), .dec_a_addr(dec_a_addr),
        .dec_b_from_rb(dec_b_from_rb), .dec_b_addr(dec_b_addr),
        .dec_z_sel(dec_z_sel), .dec_z_addr(dec_z_addr),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_inst(iss_inst),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_addr(wb_addr),
        .br_resolved(br_resolved), .br_taken(br_taken),
        .flush(flush), .halted(halted), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // reference model: mode 0=running 1=waiting on branch 2=draining 3=halted
    int m_mode;
    bit m_full;
    int m_inflight;
    bit m_busy[2][32];
    bit m_sberr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_full = 0;
        m_inflight = 0;
        m_sberr = 0;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 32; a++) m_busy[s][a] = 0;
        exp_q.delete();
    endtask

    // Monitor: every consumed issue-register word must match the oldest accepted one
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && iss_valid === 1'b1 && iss_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL iss_unexpected actual=%0h required=none", iss_inst);
                end else begin
                    chk("iss_inst", iss_inst, exp_q.pop_front());
                end
            end
        end
    end

    // Driver plus model
    initial begin
        bit hz, wz, acc, exp_rdy, exp_fl;
        int halt_cnt;
        int cand[$];

        rst = 1; dec_valid = 0; dec_inst = 0; dec_is_branch = 0; dec_halted = 0;
        dec_a_from_rb = 0; dec_a_sel = 0; dec_a_addr = 0; dec_b_from_rb = 0;
        dec_b_addr = 0; dec_z_sel = 0; dec_z_addr = 0; iss_ready = 0;
        wb_valid = 0; wb_sel = 0; wb_addr = 0; br_resolved = 0; br_taken = 0;
        model_reset();
        halt_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_iss_valid", {31'b0, iss_valid}, 0);
        chk("rst_iss_inst", iss_inst, 0);
        chk("rst_halted", {31'b0, halted}, 0);
        chk("rst_sb_err", {31'b0, sb_err}, 0);
        chk("rst_flush", {31'b0, flush}, 0);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (m_mode == 3) halt_cnt++;
            rst = (halt_cnt > 4) || (cyc % 600 == 300);
            if (rst) halt_cnt = 0;

            dec_valid     = ($urandom_range(0, 9) < 8);
            dec_inst      = $urandom;
            begin
                int r = $urandom_range(0, 99);
                dec_is_branch = (r < 10);
                dec_halted    = (r == 10);
            end
            dec_a_from_rb = $urandom_range(0, 1);
            dec_a_sel     = $urandom_range(0, 1);
            dec_a_addr    = 5'($urandom_range(0, 7));
            dec_b_from_rb = $urandom_range(0, 1);
            dec_b_addr    = 5'($urandom_range(0, 7));
            dec_z_sel     = $urandom_range(0, 1);
            dec_z_addr    = 5'($urandom_range(0, 7));
            iss_ready     = ($urandom_range(0, 9) < 7);

            cand.delete();
            for (int s = 0; s < 2; s++)
                for (int a = 0; a < 32; a++)
                    if (m_busy[s][a]) cand.push_back(s * 32 + a);
            wb_valid = 0; wb_sel = 0; wb_addr = 0;
            if (cand.size() > 0 && $urandom_range(0, 99) < 30) begin
                int k = cand[$urandom_range(0, cand.size() - 1)];
                wb_valid = 1;
                wb_sel   = (k >= 32);
                wb_addr  = 5'(k % 32);
            end else if ($urandom_range(0, 99) < 2) begin
                wb_valid = 1;
                wb_sel   = $urandom_range(0, 1);
                wb_addr  = 5'($urandom_range(0, 7));
            end
            br_resolved = (m_mode == 1) ? ($urandom_range(0, 3) == 0)
                                        : ($urandom_range(0, 19) == 0);
            br_taken    = $urandom_range(0, 1);

            #1;
            // registered outputs reflect the model state before this edge
            chk("iss_valid", {31'b0, iss_valid}, {31'b0, m_full});
            chk("halted", {31'b0, halted}, {31'b0, (m_mode == 3)});
            chk("sb_err", {31'b0, sb_err}, {31'b0, m_sberr});

            if (rst) begin
                chk("dec_ready_rst", {31'b0, dec_ready}, 0);
                chk("flush_rst", {31'b0, flush}, 0);
                model_reset();
                continue;
            end

            wz = !dec_is_branch && !dec_halted;
            hz = (dec_a_from_rb && m_busy[dec_a_sel][dec_a_addr]) ||
                 (dec_b_from_rb && m_busy[0][dec_b_addr]) ||
                 (wz && m_busy[dec_z_sel][dec_z_addr]);
            exp_rdy = (m_mode == 0) && !hz && (!m_full || iss_ready) &&
                      (!wz || m_inflight < 4);
            acc     = dec_valid && exp_rdy;
            exp_fl  = (m_mode == 1) && br_resolved && br_taken;
            chk("dec_ready", {31'b0, dec_ready}, {31'b0, exp_rdy});
            chk("flush", {31'b0, flush}, {31'b0, exp_fl});

            if (wb_valid && m_inflight == 0) m_sberr = 1;
            if (wb_valid) m_busy[wb_sel][wb_addr] = 0;
            if (acc && wz) m_busy[dec_z_sel][dec_z_addr] = 1;
            if (acc && wz && !wb_valid) m_inflight++;
            else if (!(acc && wz) && wb_valid && m_inflight > 0) m_inflight--;

            if (acc) begin
                exp_q.push_back(dec_inst);
                m_full = 1;
            end else if (m_mode == 1 && br_resolved) begin
                if (m_full && !iss_ready) void'(exp_q.pop_front());
                m_full = 0;
            end else if (iss_ready) begin
                m_full = 0;
            end

            case (m_mode)
                0: if (acc && dec_is_branch) m_mode = 1;
                   else if (acc && dec_halted) m_mode = 2;
                1: if (br_resolved) m_mode = 0;
                2: if (m_inflight == 0 && !m_full) m_mode = 3;
                default: m_mode = 3;
            endcase
        end

        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
